// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared state encoding for the bit-serial adder
// Purpose: state codes used by serial_adder.
// Ports: none (package).
package serial_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = IDLE,
    ST_RUN  = RUN,
    ST_DONE = DONE
  } state_e;

endpackage

// File: rtl/serial_adder_full_adder.sv
// rtl/serial_adder_full_adder.sv - one-bit full adder cell
// Purpose: combinational one-bit add, s = a ^ b ^ cin, carry = majority(a, b, cin).
// Ports: a_i, b_i, cin_i (operand bits, carry in); s_o (sum bit); cout_o (carry out).
module FullAdder (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic s_o,
  output logic cout_o
);

  assign s_o    = a_i ^ b_i ^ cin_i;
  assign cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial WIDTH-bit adder, LSB first, one bit per clock
// Purpose: computes {cout, sum} = a + b + cin over WIDTH clocks using one FullAdder.
// Ports: clk, rst (async, active-high); start, a, b, cin (request and operands);
//        busy (high in RUN); done (one-cycle result-valid pulse); sum, cout (held result).
module serial_adder
  import serial_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sb_q, sr_q, sum_q;
  logic             carry_q, cout_q;
  logic [CW-1:0]    cnt_q;

  logic             fa_s, fa_c;
  logic [WIDTH-1:0] sr_next;
  logic             accept, last_bit;

  FullAdder u_fa (
    .a_i   (sa_q[0]),
    .b_i   (sb_q[0]),
    .cin_i (carry_q),
    .s_o   (fa_s),
    .cout_o(fa_c)
  );

  // New sum bit enters at the MSB, so after WIDTH shifts bit 0 holds the LSB.
  always_comb begin
    sr_next            = sr_q >> 1;
    sr_next[WIDTH-1]   = fa_s;
  end

  // start is only honoured outside RUN; a request during RUN is dropped.
  assign accept   = start && (state_q != ST_RUN);
  assign last_bit = (state_q == ST_RUN) && (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN:  if (last_bit) state_d = ST_DONE;
      ST_DONE: state_d = start ? ST_RUN : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      sr_q    <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        sa_q    <= a;
        sb_q    <= b;
        carry_q <= cin;
        sr_q    <= '0;
        cnt_q   <= '0;
      end else if (state_q == ST_RUN) begin
        sa_q    <= sa_q >> 1;
        sb_q    <= sb_q >> 1;
        sr_q    <= sr_next;
        carry_q <= fa_c;
        cnt_q   <= cnt_q + CW'(1);
        // Result ports update only on the final bit so they hold across the next add.
        if (last_bit) begin
          sum_q  <= sr_next;
          cout_q <= fa_c;
        end
      end
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule
